id_ex_stage: RTL

Pipeline register between the decode stage (control unit, register file, immediate generator) and the execute stage. It also contains the load-use hazard detector. Each cycle it captures the decoded control bundle and operands. When a load in EX feeds the instruction in ID, it inserts a bubble and stalls the front end. A branch-taken flush from MEM zeroes the captured control. A saturating counter records how many cycles were stalled.

---
 rtl/id_ex_if.sv | 59 +++++
 rtl/id_ex_stage.sv | 109 ++++++++++
 2 files changed

// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded inputs from the front end, registered EX outputs,
// the load-use stall request and the stall counter.
interface id_ex_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             flush;
  logic             id_valid;
  logic             alu_src;
  logic             branch;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic [1:0]       alu_op;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [3:0]       id_funct;

  logic             stall;
  logic             ex_valid;
  logic             ex_alu_src;
  logic             ex_branch;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_mem_to_reg;
  logic             ex_reg_write;
  logic [1:0]       ex_alu_op;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [3:0]       ex_funct;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output flush, id_valid, alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write,
           alu_op, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct,
    input  stall, ex_valid, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_reg_write, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_funct, stall_count
  );

  modport slave (
    input  flush, id_valid, alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write,
           alu_op, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct,
    output stall, ex_valid, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_reg_write, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_funct, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and a
// saturating stall-cycle counter.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic  clk,
  input  logic  reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      funct;
  } data_t;

  logic             valid_d, valid_q;
  ctrl_t            ctrl_d, ctrl_q;
  data_t            data_d, data_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             uses_rs2;
  logic             hazard;
  logic             stall;

  always_comb begin
    uses_rs2 = ~bus.alu_src | bus.mem_write;
    hazard   = valid_q & ctrl_q.mem_read & (data_q.rd != '0) & bus.id_valid &
               ((bus.id_rs1 == data_q.rd) | (uses_rs2 & (bus.id_rs2 == data_q.rd)));
    // A flushed ID instruction is discarded anyway, so it must not hold the front end.
    stall    = hazard & ~bus.flush;

    data_d.pc       = bus.id_pc;
    data_d.rs1_data = bus.id_rs1_data;
    data_d.rs2_data = bus.id_rs2_data;
    data_d.imm      = bus.id_imm;
    data_d.rs1      = bus.id_rs1;
    data_d.rs2      = bus.id_rs2;
    data_d.rd       = bus.id_rd;
    data_d.funct    = bus.id_funct;

    valid_d = bus.id_valid & ~bus.flush & ~stall;
    ctrl_d  = '0;
    if (valid_d) begin
      ctrl_d.alu_src    = bus.alu_src;
      ctrl_d.branch     = bus.branch;
      ctrl_d.mem_read   = bus.mem_read;
      ctrl_d.mem_write  = bus.mem_write;
      // Stores and branches leave mem_to_reg undefined; gating with reg_write pins it to 0.
      ctrl_d.mem_to_reg = bus.mem_to_reg & bus.reg_write;
      ctrl_d.reg_write  = bus.reg_write;
      ctrl_d.alu_op     = bus.alu_op;
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_branch     = ctrl_q.branch;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_alu_op     = ctrl_q.alu_op;
  assign bus.ex_pc         = data_q.pc;
  assign bus.ex_rs1_data   = data_q.rs1_data;
  assign bus.ex_rs2_data   = data_q.rs2_data;
  assign bus.ex_imm        = data_q.imm;
  assign bus.ex_rs1        = data_q.rs1;
  assign bus.ex_rs2        = data_q.rs2;
  assign bus.ex_rd         = data_q.rd;
  assign bus.ex_funct      = data_q.funct;
  assign bus.stall_count   = cnt_q;

endmodule
